jk_excite_driver: RTL

- Drives a bank of W external JK flip-flops so they reach a requested next-state word.
- Implements the JK excitation (inverse characteristic) table: it takes a target word, reads the current Q feedback, generates the J/K pulse for one clock, then checks the result.
- Sits between a sequence source (valid/ready) and a jkff bank; reports completion and per-bit mismatch.

---
 rtl/jk_excite_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - JK excitation driver: steers an external JK bank to a target word, then checks it (optional JKX_ERR_CNT_EN)
module jk_excite_driver #(
    parameter int W      = 4,
    parameter bit DC_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_data,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         done,
    output logic         mismatch,
    output logic [W-1:0] err_bits,
`ifdef JKX_ERR_CNT_EN
    output logic [7:0]   err_cnt,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_ready, w_ready_nxt;
    logic [W-1:0]   r_j, w_j_nxt;
    logic [W-1:0]   r_k, w_k_nxt;
    logic           r_done, w_done_nxt;
    logic           r_mismatch, w_mismatch_nxt;
    logic [W-1:0]   r_err_bits, w_err_bits_nxt;
    logic [W-1:0]   r_target, w_target_nxt;
    logic [W-1:0]   w_dc;
    logic [W-1:0]   w_diff;

    assign w_dc   = {W{DC_VAL}};
    assign w_diff = q_fb ^ r_target;

    always_comb begin
        w_state_nxt    = r_state;
        w_ready_nxt    = r_ready;
        w_j_nxt        = '0;
        w_k_nxt        = '0;
        w_done_nxt     = 1'b0;
        w_mismatch_nxt = 1'b0;
        w_err_bits_nxt = r_err_bits;
        w_target_nxt   = r_target;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (tgt_valid && r_ready) begin
                    w_target_nxt = tgt_data;
                    // Inverse JK table; don't-care entries resolved to DC_VAL
                    w_j_nxt      = (~q_fb & tgt_data) | (q_fb & w_dc);
                    w_k_nxt      = (q_fb & ~tgt_data) | (~q_fb & w_dc);
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_done_nxt     = 1'b1;
                w_mismatch_nxt = |w_diff;
                w_err_bits_nxt = w_diff;
                w_ready_nxt    = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_j        <= '0;
            r_k        <= '0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_bits <= '0;
            r_target   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_done     <= w_done_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_err_bits <= w_err_bits_nxt;
            r_target   <= w_target_nxt;
        end
    end

`ifdef JKX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (r_state == S_CHECK && (|w_diff) && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign tgt_ready = r_ready;
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign err_bits  = r_err_bits;
    assign busy      = (r_state != S_IDLE);

endmodule
